// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm
// Purpose  : Multi-cycle control unit for the BEAN-2 core. Latches the
//            fetched instruction into ir and steps it through FETCH, DECODE,
//            EXEC, MEM and WB. It drives every datapath select and write
//            enable, plus the dmem control pair. The PC moves only in the
//            final (retiring) cycle of each instruction. Illegal opcodes, and
//            ECALL/EBREAK when HALT_ON_ECALL=1, park the unit in HALT until
//            reset.
// Ports    : clk, reset (async, active-high)
//            Instr[31:0] imem data, br_taken branch comparator result
//            reg_WE, rs1_SEL, rs2_SEL, pc_SEL[1:0], reg_SEL[1:0],
//            imm_SEL[2:0], ALU_SEL[3:0] datapath controls
//            dmem_WE, dmem_SEL[2:0] data memory controls
//            halt, retired[31:0], state[2:0] status
// Revision : 1.0 - initial release
// ============================================================================
module control_fsm #(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        br_taken,
  output logic        reg_WE,
  output logic        rs1_SEL,
  output logic        rs2_SEL,
  output logic [1:0]  pc_SEL,
  output logic [1:0]  reg_SEL,
  output logic [2:0]  imm_SEL,
  output logic [3:0]  ALU_SEL,
  output logic        dmem_WE,
  output logic [2:0]  dmem_SEL,
  output logic        halt,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALT   = 3'b111
  } state_t;

  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_fence  = 7'b0001111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

  localparam logic [2:0] c_imm_i = 3'b000;
  localparam logic [2:0] c_imm_s = 3'b001;
  localparam logic [2:0] c_imm_b = 3'b010;
  localparam logic [2:0] c_imm_u = 3'b011;
  localparam logic [2:0] c_imm_j = 3'b100;

  localparam logic [1:0] c_rs_alu = 2'b00;
  localparam logic [1:0] c_rs_imm = 2'b01;
  localparam logic [1:0] c_rs_mem = 2'b10;
  localparam logic [1:0] c_rs_pc4 = 2'b11;

  localparam logic [1:0] c_pc_plus4 = 2'b00;
  localparam logic [1:0] c_pc_imm   = 2'b01;
  localparam logic [1:0] c_pc_alu   = 2'b10;
  localparam logic [1:0] c_pc_hold  = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] ir_q;
  logic [31:0] retired_q;

  // Instruction fields, always taken from the latched ir (never from Instr,
  // which may already show the next fetch address's data).
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [4:0] w_rd;
  assign w_opc = ir_q[6:0];
  assign w_f3  = ir_q[14:12];
  assign w_rd  = ir_q[11:7];

  // Bits of ir that no control decision depends on.
  logic w_unused;
  assign w_unused = ^{ir_q[31], ir_q[29:15]};

  // Per-instruction selects; held steady across EXEC, MEM and WB.
  logic       w_legal;
  logic       w_rs1_sel;
  logic       w_rs2_sel;
  logic [2:0] w_imm_sel;
  logic [3:0] w_alu_sel;
  logic [1:0] w_reg_sel;
  logic [2:0] w_dmem_sel;
  logic [1:0] w_pc_wb;

  always_comb begin
    w_legal    = 1'b1;
    w_rs1_sel  = 1'b0;
    w_rs2_sel  = 1'b0;
    w_imm_sel  = c_imm_i;
    w_alu_sel  = 4'b0000;
    w_reg_sel  = c_rs_alu;
    w_dmem_sel = 3'b000;
    w_pc_wb    = c_pc_plus4;
    case (w_opc)
      c_opc_op: begin
        w_alu_sel = {ir_q[30], w_f3};
      end
      c_opc_opimm: begin
        // bit30 only distinguishes SRLI/SRAI; elsewhere it is immediate data.
        w_rs2_sel = 1'b1;
        w_alu_sel = {(w_f3 == 3'b101) ? ir_q[30] : 1'b0, w_f3};
      end
      c_opc_lui: begin
        w_imm_sel = c_imm_u;
        w_reg_sel = c_rs_imm;
      end
      c_opc_auipc: begin
        w_rs1_sel = 1'b1;
        w_rs2_sel = 1'b1;
        w_imm_sel = c_imm_u;
      end
      c_opc_load: begin
        w_rs2_sel  = 1'b1;
        w_reg_sel  = c_rs_mem;
        w_dmem_sel = w_f3;
      end
      c_opc_store: begin
        w_rs2_sel  = 1'b1;
        w_imm_sel  = c_imm_s;
        w_dmem_sel = w_f3;
      end
      c_opc_branch: begin
        w_imm_sel = c_imm_b;
      end
      c_opc_jal: begin
        w_imm_sel = c_imm_j;
        w_reg_sel = c_rs_pc4;
        w_pc_wb   = c_pc_imm;
      end
      c_opc_jalr: begin
        w_rs2_sel = 1'b1;
        w_reg_sel = c_rs_pc4;
        w_pc_wb   = c_pc_alu;
      end
      c_opc_fence, c_opc_system: begin
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    reg_WE   = 1'b0;
    rs1_SEL  = 1'b0;
    rs2_SEL  = 1'b0;
    pc_SEL   = c_pc_hold;
    reg_SEL  = c_rs_alu;
    imm_SEL  = c_imm_i;
    ALU_SEL  = 4'b0000;
    dmem_WE  = 1'b0;
    dmem_SEL = 3'b000;
    halt     = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal || ((w_opc == c_opc_system) && HALT_ON_ECALL)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC, S_MEM, S_WB: begin
        rs1_SEL  = w_rs1_sel;
        rs2_SEL  = w_rs2_sel;
        imm_SEL  = w_imm_sel;
        ALU_SEL  = w_alu_sel;
        reg_SEL  = w_reg_sel;
        dmem_SEL = w_dmem_sel;
        if (state_q == S_EXEC) begin
          case (w_opc)
            c_opc_load, c_opc_store: begin
              state_d = S_MEM;
            end
            c_opc_branch: begin
              pc_SEL  = br_taken ? c_pc_imm : c_pc_plus4;
              state_d = S_FETCH;
            end
            c_opc_fence, c_opc_system: begin
              pc_SEL  = c_pc_plus4;
              state_d = S_FETCH;
            end
            default: begin
              state_d = S_WB;
            end
          endcase
        end else if (state_q == S_MEM) begin
          if (w_opc == c_opc_store) begin
            dmem_WE = 1'b1;
            pc_SEL  = c_pc_plus4;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          reg_WE  = (w_rd != 5'd0);
          pc_SEL  = w_pc_wb;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // An instruction retires on any edge that returns from EXEC/MEM/WB to FETCH.
  logic w_retire;
  assign w_retire = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
                    && (state_d == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'h0000_0013;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        ir_q <= Instr;
      end
      if (w_retire) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the BEAN-2 core, sitting directly upstream of `datapath` and driving every select and write-enable it consumes, plus the `dmem` control pair. It latches the fetched instruction, sequences it through FETCH/DECODE/EXEC/MEM/WB, and advances the PC only in the final cycle of each instruction. It also counts retired instructions and halts on illegal opcodes or ECALL/EBREAK.

## Interface
- HALT_ON_ECALL, 1, when 1 ECALL/EBREAK (opcode 1110011) enter HALT; when 0 they retire as a NOP.

- clk  in  1  core clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- Instr  in  32  imem read data for current pc (combinational).
- br_taken  in  1  datapath comparator result for condition Instr[14:12] on rs1/rs2.
- reg_WE  out  1  regfile write enable.
- rs1_SEL  out  1  0 = rs1 register, 1 = pc.
- rs2_SEL  out  1  0 = rs2 register, 1 = immediate.
- pc_SEL  out  2  00 pc+4, 01 pc+imm, 10 ALU result (bit0 cleared by datapath), 11 hold.
- reg_SEL  out  2  00 ALU, 01 immediate, 10 memDataRD, 11 pc+4.
- imm_SEL  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- ALU_SEL  out  4  {bit30, funct3}; 0000 = add.
- dmem_WE  out  1  data memory write enable.
- dmem_SEL  out  3  access mode = funct3 of load/store, else 000.
- halt  out  1  1 while in HALT.
- retired  out  32  retired-instruction count.
- state  out  3  FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 111.

## Operation
- Internal ir register; loaded from Instr on the edge leaving FETCH. All outputs except in FETCH/HALT decode from ir and state.
- FETCH: all enables 0, pc_SEL 11. -> DECODE.
- DECODE: enables 0, pc_SEL 11; illegal opcode, or ECALL/EBREAK with HALT_ON_ECALL=1 -> HALT; else -> EXEC.
- EXEC (selects set per opcode, enables 0 unless listed):
  - OP (0110011): rs2_SEL 0, ALU_SEL {ir[30],funct3}. -> WB.
  - OP-IMM (0010011): rs2_SEL 1, imm I; ALU_SEL {ir[30] only if funct3=101 else 0, funct3}. -> WB.
  - LUI: imm U, reg_SEL 01. AUIPC: rs1_SEL 1, rs2_SEL 1, imm U, add. -> WB.
  - LOAD: rs2_SEL 1, imm I, add -> MEM. STORE: rs2_SEL 1, imm S, add -> MEM.
  - BRANCH: imm B, pc_SEL = br_taken ? 01 : 00 -> FETCH (retires).
  - JAL: imm J -> WB. JALR: rs2_SEL 1, imm I, add -> WB.
  - FENCE, or ECALL/EBREAK with HALT_ON_ECALL=0: pc_SEL 00 -> FETCH (retires).
- MEM: address selects held; dmem_SEL = funct3. STORE: dmem_WE 1, pc_SEL 00 -> FETCH (retires). LOAD: dmem_WE 0 -> WB.
- WB: reg_WE = (rd != 0); selects held from EXEC/MEM; reg_SEL 00 ALU, 01 LUI, 10 LOAD, 11 JAL/JALR; pc_SEL 01 JAL, 10 JALR, else 00. -> FETCH (retires).
- Legal opcodes: the eleven above; anything else (incl. ir[1:0]!=11) is illegal.
- HALT: enables 0, pc_SEL 11, halt 1; exits only via reset.
- retired increments by 1 on each retiring edge; wraps 0xFFFFFFFF -> 0.

## Timing
- Reset (async): state FETCH, ir 0x00000013, retired 0, halt 0; outputs immediately reg_WE 0, dmem_WE 0, pc_SEL 11, all selects 0.
- Cycles per instruction: ALU/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, BRANCH/FENCE 3.
- PC changes only on the edge ending the retiring state; pc+4 in WB of JAL/JALR is the instruction's own pc+4.
- Outputs are combinational from state/ir; pc_SEL in branch EXEC also from br_taken (must be stable before edge).
- Reset mid-instruction: enables drop in the same cycle; no partial store or regfile write on the next edge; retired not incremented.
- rd = x0: reg_WE held 0 throughout WB.

## Test plan
- addi x1,x0,5 (0x00500093) -> states 000,001,010,100; WB: reg_WE 1, rs2_SEL 1, imm 000, ALU 0000, reg_SEL 00, pc_SEL 00; retired 1.
- lw x2,4(x1) (0x0040a103) -> 5 cycles; MEM dmem_WE 0, dmem_SEL 010; WB reg_SEL 10, reg_WE 1.
- sw x2,4(x1) (0x0020a223) -> MEM dmem_WE 1, imm 001, dmem_SEL 010, pc_SEL 00; no WB, reg_WE never 1.
- beq (0x00208463) with br_taken 1 -> EXEC pc_SEL 01; with 0 -> 00; 3 cycles each.
- 0xFFFFFFFF then ecall (0x00000073) -> HALT after DECODE, halt 1 for 20 cycles, retired unchanged; reset clears to FETCH.
- Reset asserted mid-MEM of sw -> dmem_WE 0 same cycle, state 000, retired unchanged.
